bit_serial_alu: RTL and testbench
=================================

# bit_serial_alu

Bit-serial execute stage of the processor. Accepts two parallel operands from the register file read ports, processes them LSB-first one bit per clock through a 1-bit adder/logic slice, and presents a parallel result with a write-enable and destination index for the register file write port. One operation is in flight at a time; a start/busy/done handshake sequences it.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- AW, 5, register index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  request; sampled only in IDLE
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLTU, 110 SLT, 111 PASSB
- a  in  WIDTH  operand A (from rd1)
- b  in  WIDTH  operand B (from rd2)
- rd_in  in  AW  destination index
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  result word; held until next accepted start
- wb_we  out  1  equals done; drives register file we
- wb_rd  out  AW  destination latched at start
- zero  out  1  only with BSALU_ZERO_FLAG_EN; result == 0

## Operation
- Clock is clk; reset is asynchronous, active-high on rst.
- States: IDLE, SHIFT, DONE.
- IDLE: on start=1 latch a→SA, b→SB, op, rd_in→wb_rd; bit counter cnt←0; carry←1 for SUB/SLTU/SLT else 0; → SHIFT. start=0: stay.
- SHIFT, each cycle: bb = SB[0] ^ (op ∈ {SUB,SLTU,SLT}); s = SA[0]^bb^carry; carry←majority(SA[0],bb,carry); result bit per op (ADD/SUB/SLT*: s; AND/OR/XOR: logic of SA[0],SB[0]; PASSB: SB[0]); shift SA, SB right by 1; shift result bit into result MSB (result right-shifts). cnt increments; at cnt==WIDTH-1 → DONE.
- On the last SHIFT cycle (bit WIDTH-1) for compare ops, result is overwritten with zero-extended flag: SLTU flag = ~carry_out; SLT flag = s ^ (carry_in ^ carry_out).
- DONE: done=1, wb_we=1 for one cycle; → IDLE.
- start in SHIFT or DONE is ignored (no queueing). Operand inputs are don't-care except in the start cycle.
- Arithmetic is modulo 2^WIDTH; carry-out discarded except for compares.
- Reset at any time: state←IDLE, cnt←0, carry←0, result←0, wb_rd←0; in-flight op is dropped and no write-back is issued.

## Timing
- Reset values: busy=0, done=0, wb_we=0, result=0, wb_rd=0, zero=1 (if present).
- start accepted at edge E0 → busy=1 from E0 through edge E0+WIDTH+1; done/wb_we high for exactly the cycle between E0+WIDTH and E0+WIDTH+1.
- Total latency start→done: WIDTH+1 cycles (33 at default). Back-to-back: next start accepted at E0+WIDTH+1 earliest, i.e. one op per WIDTH+1 cycles.
- result, wb_rd stable during the done cycle and after, until the next accepted start.
- rd_in=0 still pulses wb_we; the register file discards writes to index 0.

## Configuration
- BSALU_ZERO_FLAG_EN defined: adds port zero, a registered flag cleared when any 1 bit shifts into result, set at start, valid in the done cycle and held thereafter (compare ops: reflects final overwritten result).
- Undefined: zero port and its flop are absent; all other behaviour identical.

## Test plan
- ADD a=0x7FFFFFFF, b=1, rd_in=5 → done 33 cycles after start, result=0x80000000, wb_rd=5, wb_we one cycle.
- SUB a=0, b=1 → result=0xFFFFFFFF; SLTU a=0, b=1 → result=1; SLT a=0x80000000, b=1 → result=1; SLT a=1, b=0x80000000 → result=0.
- AND/OR/XOR a=0xF0F0F0F0, b=0xFF00FF00 → 0xF000F000 / 0xFFF0FFF0 / 0x0FF00FF0; PASSB b=0x12345678 → 0x12345678.
- start held high continuously with changing a/b → only operands present at each IDLE acceptance used; done every 33 cycles, no missed or double write-backs.
- rst pulsed at cycle 10 of an ADD → busy, done, wb_we, result drop to 0 immediately; no wb_we pulse; next start completes correctly.
- With BSALU_ZERO_FLAG_EN: SUB a=b=0xDEADBEEF → result=0, zero=1 in done cycle; ADD 1+1 → zero=0.

Source files
------------

// File: rtl/bit_serial_alu.sv
// Bit-serial execute stage: LSB-first 1-bit adder/logic slice with register-file write-back.
// Optional BSALU_ZERO_FLAG_EN adds a registered result==0 flag on port zero.
module bit_serial_alu #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [AW-1:0]    rd_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             wb_we,
    output logic [AW-1:0]    wb_rd
`ifdef BSALU_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_SLTU, OP_SLT, OP_PASSB
    } op_e;

    state_e state, state_nxt;
    op_e opr;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0] cnt;
    logic carry;

    logic last, inv, cmp, bb, s, cout, rbit, flag;
    logic start_sub;

    always_comb begin
        last = (cnt == LAST);
        inv  = opr inside {OP_SUB, OP_SLTU, OP_SLT};
        cmp  = opr inside {OP_SLTU, OP_SLT};
        bb   = sb[0] ^ inv;
        s    = sa[0] ^ bb ^ carry;
        cout = (sa[0] & bb) | (sa[0] & carry) | (bb & carry);
        case (opr)
            OP_AND:   rbit = sa[0] & sb[0];
            OP_OR:    rbit = sa[0] | sb[0];
            OP_XOR:   rbit = sa[0] ^ sb[0];
            OP_PASSB: rbit = sb[0];
            default:  rbit = s;
        endcase
        // Signed less-than is N xor V, with V taken from the MSB carries.
        flag = (opr == OP_SLT) ? (s ^ (carry ^ cout)) : ~cout;
        start_sub = op_e'(op) inside {OP_SUB, OP_SLTU, OP_SLT};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            opr    <= OP_ADD;
            cnt    <= '0;
            carry  <= 1'b0;
            result <= '0;
            wb_rd  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        opr   <= op_e'(op);
                        wb_rd <= rd_in;
                        cnt   <= '0;
                        carry <= start_sub;
                    end
                end
                SHIFT: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    carry <= cout;
                    cnt   <= cnt + 1'b1;
                    if (last && cmp) begin
                        result <= {{(WIDTH-1){1'b0}}, flag};
                    end else begin
                        result <= {rbit, result[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BSALU_ZERO_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero <= 1'b1;
        end else if (state == IDLE && start) begin
            zero <= 1'b1;
        end else if (state == SHIFT) begin
            if (last && cmp) begin
                zero <= ~flag;
            end else if (rbit) begin
                zero <= 1'b0;
            end
        end
    end
`endif

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign wb_we = done;

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed bench for bit_serial_alu: operations, handshake timing, held start, reset abort.
module tb_bit_serial_alu;

    localparam int W  = 32;
    localparam int AW = 5;

    localparam logic [2:0] ADD   = 3'b000;
    localparam logic [2:0] SUB   = 3'b001;
    localparam logic [2:0] AND_  = 3'b010;
    localparam logic [2:0] OR_   = 3'b011;
    localparam logic [2:0] XOR_  = 3'b100;
    localparam logic [2:0] SLTU  = 3'b101;
    localparam logic [2:0] SLT   = 3'b110;
    localparam logic [2:0] PASSB = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [2:0] op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [AW-1:0] rd_in = '0;
    logic busy, done, wb_we;
    logic [W-1:0] result;
    logic [AW-1:0] wb_rd;
`ifdef BSALU_ZERO_FLAG_EN
    logic zero;
`endif

    int checks = 0;
    int errors = 0;
    int wbn = 0;

    bit_serial_alu #(.WIDTH(W), .AW(AW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .rd_in(rd_in),
        .busy(busy),
        .done(done),
        .result(result),
        .wb_we(wb_we),
        .wb_rd(wb_rd)
`ifdef BSALU_ZERO_FLAG_EN
        ,
        .zero(zero)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wb_we) wbn++;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [AW-1:0] r, input logic [W-1:0] exp,
                       input bit hold);
        int n;
        int w0;
        bit got;
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        rd_in = r;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_accept"}, W'(got), 1);
        start = hold;
        a = $urandom;
        b = $urandom;
        rd_in = ~r;
        op = ~o;
        w0 = wbn;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
        chk({tag, "_latency"}, n, W);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_wb_rd"}, W'(wb_rd), W'(r));
        chk({tag, "_wb_we"}, W'(wb_we), 1);
        chk({tag, "_busy_done"}, W'(busy), 1);
`ifdef BSALU_ZERO_FLAG_EN
        chk({tag, "_zero"}, W'(zero), W'(exp == '0));
`endif
        @(posedge clk);
        #1;
        chk({tag, "_done_end"}, W'(done), 0);
        chk({tag, "_busy_end"}, W'(busy), 0);
        chk({tag, "_held"}, result, exp);
        chk({tag, "_wbcount"}, wbn, w0 + 1);
    endtask

    initial begin
        int w0;
        repeat (2) @(negedge clk);
        chk("rst_busy", W'(busy), 0);
        chk("rst_done", W'(done), 0);
        chk("rst_wb_we", W'(wb_we), 0);
        chk("rst_result", result, 0);
        chk("rst_wb_rd", W'(wb_rd), 0);
`ifdef BSALU_ZERO_FLAG_EN
        chk("rst_zero", W'(zero), 1);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", W'(busy), 0);

        run("add_ovf", ADD, 32'h7FFF_FFFF, 32'h1, 5'd5, 32'h8000_0000, 1'b0);
        run("sub_neg", SUB, 32'h0, 32'h1, 5'd1, 32'hFFFF_FFFF, 1'b0);
        run("sub_pos", SUB, 32'h5, 32'h3, 5'd2, 32'h2, 1'b0);
        run("add_wrap", ADD, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0);
        run("sltu_lt", SLTU, 32'h0, 32'h1, 5'd3, 32'h1, 1'b0);
        run("sltu_gt", SLTU, 32'h1, 32'h0, 5'd4, 32'h0, 1'b0);
        run("sltu_max", SLTU, 32'hFFFF_FFFF, 32'h0, 5'd6, 32'h0, 1'b0);
        run("sltu_0max", SLTU, 32'h0, 32'hFFFF_FFFF, 5'd7, 32'h1, 1'b0);
        run("slt_min", SLT, 32'h8000_0000, 32'h1, 5'd8, 32'h1, 1'b0);
        run("slt_rev", SLT, 32'h1, 32'h8000_0000, 5'd9, 32'h0, 1'b0);
        run("slt_m1", SLT, 32'hFFFF_FFFF, 32'h0, 5'd10, 32'h1, 1'b0);
        run("slt_eq", SLT, 32'h5, 32'h5, 5'd11, 32'h0, 1'b0);
        run("and", AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd12, 32'hF000_F000, 1'b0);
        run("or", OR_, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd13, 32'hFFF0_FFF0, 1'b0);
        run("xor", XOR_, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd14, 32'h0FF0_0FF0, 1'b0);
        run("passb", PASSB, 32'hFFFF_FFFF, 32'h1234_5678, 5'd31, 32'h1234_5678, 1'b0);

        run("hold_add", ADD, 32'h1, 32'h2, 5'd17, 32'h3, 1'b1);
        run("hold_xor", XOR_, 32'hAAAA_AAAA, 32'h5555_5555, 5'd18, 32'hFFFF_FFFF, 1'b1);
        run("hold_passb", PASSB, 32'h0, 32'hCAFE_F00D, 5'd19, 32'hCAFE_F00D, 1'b0);

        @(negedge clk);
        start = 1'b1;
        op = ADD;
        a = 32'h3;
        b = 32'h4;
        rd_in = 5'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", W'(busy), 0);
        chk("abort_done", W'(done), 0);
        chk("abort_wb_we", W'(wb_we), 0);
        chk("abort_result", result, 0);
        chk("abort_wb_rd", W'(wb_rd), 0);
`ifdef BSALU_ZERO_FLAG_EN
        chk("abort_zero", W'(zero), 1);
`endif
        w0 = wbn;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_wb", wbn, w0);
        chk("abort_idle", W'(busy), 0);
        run("after_rst", ADD, 32'h3, 32'h4, 5'd7, 32'h7, 1'b0);

        run("sub_same", SUB, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd20, 32'h0, 1'b0);
        run("add_11", ADD, 32'h1, 32'h1, 5'd21, 32'h2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
